// File: rtl/rr_muxn.sv
// N-channel registered mux with per-channel valid/ready and round-robin or
// fixed-priority arbitration onto one output register.
module rr_muxn #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 2,
    parameter int MODE  = 0
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [(2**SEL_W)*WIDTH-1:0] in_data,
    input  logic [(2**SEL_W)-1:0]       in_valid,
    output logic [(2**SEL_W)-1:0]       in_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [SEL_W-1:0]            out_sel,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int N_CH = 2**SEL_W;

    // Handshake: a word moves on any edge where valid and ready are both high.
    // in_ready never depends on the word content, only on in_valid, the grant and
    // whether the output register is free or being drained in the same cycle.

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] base;
    logic [SEL_W-1:0] cand;
    logic [SEL_W-1:0] gnt_idx;
    logic             gnt_found;
    logic             load_en;
    logic             xfer;
    logic [N_CH-1:0]  one_hot;

    assign load_en = rstn & (~out_valid | out_ready);
    assign base    = (MODE == 0) ? ptr : '0;
    assign one_hot = {{(N_CH-1){1'b0}}, 1'b1};

    // Search ascending from base; the index wraps naturally at N_CH = 2**SEL_W.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_CH; k++) begin
            cand = base + SEL_W'(k);
            if (!gnt_found && in_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign xfer     = load_en & gnt_found;
    assign in_ready = xfer ? (one_hot << gnt_idx) : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[gnt_idx*WIDTH +: WIDTH];
            out_sel   <= gnt_idx;
            if (MODE == 0) begin
                ptr <= gnt_idx + SEL_W'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_muxn.sv
// Bench for rr_muxn: a round-robin and a fixed-priority instance share one
// stimulus stream and are checked against a behavioural model every cycle.
module tb_rr_muxn;

    logic        clk;
    logic        rstn;
    logic [63:0] in_data;
    logic [3:0]  in_valid;
    logic        out_ready;

    logic [3:0]  rdy[2];
    logic [15:0] odata[2];
    logic [1:0]  osel[2];
    logic        ovalid[2];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];

    // model state, index 0 = round-robin, 1 = fixed priority
    logic        m_valid[2];
    logic [15:0] m_data[2];
    int          m_sel[2];
    int          m_ptr[2];

    rr_muxn #(.WIDTH(16), .SEL_W(2), .MODE(0)) dut_rr (
        .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy[0]), .out_data(odata[0]), .out_sel(osel[0]),
        .out_valid(ovalid[0]), .out_ready(out_ready)
    );

    rr_muxn #(.WIDTH(16), .SEL_W(2), .MODE(1)) dut_fp (
        .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy[1]), .out_data(odata[1]), .out_sel(osel[1]),
        .out_valid(ovalid[1]), .out_ready(out_ready)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner among valid channels: round-robin from pointer p, or lowest index.
    function automatic int pick(input int mode, input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (mode == 0) ? (p + k) % 4 : k;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_ready(input int d);
        int g;
        g = pick(d, in_valid, m_ptr[d]);
        if (!rstn || (m_valid[d] && !out_ready) || g < 0) return 4'b0000;
        return 4'b0001 << g;
    endfunction

    // behavioural model
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int g;
            g = pick(d, in_valid, m_ptr[d]);
            if (!rstn) begin
                m_valid[d] <= 1'b0;
                m_data[d]  <= 16'h0;
                m_sel[d]   <= 0;
                m_ptr[d]   <= 0;
            end else if ((!m_valid[d] || out_ready) && g >= 0) begin
                m_valid[d] <= 1'b1;
                m_data[d]  <= in_data[g*16 +: 16];
                m_sel[d]   <= g;
                if (d == 0) m_ptr[d] <= (g + 1) % 4;
            end else if (out_ready) begin
                m_valid[d] <= 1'b0;
            end
        end
    end

    // compare process, mid-cycle
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("model in_ready[%0d]", d), 32'(rdy[d]), 32'(model_ready(d)));
            chk($sformatf("model out_valid[%0d]", d), 32'(ovalid[d]), 32'(m_valid[d]));
            chk($sformatf("model out_data[%0d]", d), 32'(odata[d]), 32'(m_data[d]));
            chk($sformatf("model out_sel[%0d]", d), 32'(osel[d]), 32'(m_sel[d]));
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [15:0] d0, input logic [15:0] d1,
                            input logic [15:0] d2, input logic [15:0] d3);
        in_data = {d3, d2, d1, d0};
    endtask

    initial begin
        rstn      = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        set_data(16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3);

        // reset held two clocks with all channels valid
        for (int i = 0; i < 2; i++) begin
            step();
            chk("reset out_valid", 32'(ovalid[0]), 32'd0);
            chk("reset out_data", 32'(odata[0]), 32'd0);
            chk("reset out_sel", 32'(osel[0]), 32'd0);
            chk("reset in_ready rr", 32'(rdy[0]), 32'd0);
            chk("reset in_ready fp", 32'(rdy[1]), 32'd0);
        end

        // round-robin fairness, no bubbles
        rstn      = 1'b1;
        out_ready = 1'b1;
        exp_q = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
        while (exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            step();
            chk("rr seq out_valid", 32'(ovalid[0]), 32'd1);
            chk("rr seq out_sel", 32'(osel[0]), e);
            chk("rr seq out_data", 32'(odata[0]), 32'h00A0 + e);
        end

        // pointer wrap and skip: ch2 grant leaves pointer at 3
        in_valid = 4'b0100;
        step();
        chk("skip ch2 first", 32'(osel[0]), 32'd2);
        in_valid = 4'b0110;
        step();
        chk("wrap ch1", 32'(osel[0]), 32'd1);
        step();
        chk("wrap ch2", 32'(osel[0]), 32'd2);
        in_valid = 4'b0000;
        step();
        chk("drain out_valid", 32'(ovalid[0]), 32'd0);
        chk("drain stale sel", 32'(osel[0]), 32'd2);

        // backpressure
        set_data(16'h00B0, 16'h00A1, 16'h00A2, 16'h00A3);
        in_valid = 4'b0001;
        step();
        chk("bp load", 32'(odata[0]), 32'h00B0);
        out_ready = 1'b0;
        set_data(16'h00B1, 16'h00A1, 16'h00A2, 16'h00A3);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp hold data", 32'(odata[0]), 32'h00B0);
            chk("bp hold valid", 32'(ovalid[0]), 32'd1);
            chk("bp in_ready", 32'(rdy[0]), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 32'(rdy[0]), 32'b0001);
        step();
        chk("bp refill data", 32'(odata[0]), 32'h00B1);
        chk("bp refill valid", 32'(ovalid[0]), 32'd1);

        // fixed priority: ch0 starves ch3
        set_data(16'h00C0, 16'h00A1, 16'h00A2, 16'h00C3);
        in_valid = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fp ch0 wins", 32'(osel[1]), 32'd0);
            chk("fp ch0 data", 32'(odata[1]), 32'h00C0);
        end
        in_valid = 4'b1000;
        step();
        chk("fp ch3 after drop", 32'(osel[1]), 32'd3);
        chk("fp ch3 data", 32'(odata[1]), 32'h00C3);

        // reset mid-stream
        set_data(16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3);
        in_valid = 4'b1111;
        step();
        chk("pre-reset grant", 32'(osel[0]), 32'd0);
        out_ready = 1'b0;
        step();
        rstn = 1'b0;
        step();
        chk("mid reset out_valid", 32'(ovalid[0]), 32'd0);
        chk("mid reset out_sel", 32'(osel[0]), 32'd0);
        chk("mid reset out_data", 32'(odata[0]), 32'd0);
        rstn      = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post reset ptr0 sel", 32'(osel[0]), 32'd0);
        chk("post reset ptr0 data", 32'(odata[0]), 32'h00A0);

        // mixed traffic checked by the model
        for (int i = 0; i < 60; i++) begin
            in_valid  = 4'($urandom_range(0, 15));
            out_ready = 1'($urandom_range(0, 1));
            set_data(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            step();
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
